// File: rtl/reg_native_if_arb_pkg.sv
// Shared types and limits for the reg_native_if arbiter.
package reg_native_if_arb_pkg;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_native_if_rr_arb.sv
// Round-robin selector: picks the first pending requester after last_idx.
module reg_native_if_rr_arb
  import reg_native_if_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         pending,
  input  logic [$clog2(N_REQ)-1:0] last_idx,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_vld
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] idx;

  // Scan from last_idx+1 around the ring; the first pending index wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_idx) + k) % N_REQ);
      if (!grant_vld && pending[idx]) begin
        grant[idx] = 1'b1;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_native_if_arbiter.sv
// N-to-1 reg_native_if arbiter with one outstanding downstream transaction.
// Optional WAIT timeout enabled by macro REG_NATIVE_IF_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | nothing outstanding; grant next pending requester round-robin
// ST_ISSUE | ext_req_vld high for the granted capture (one cycle)
// ST_WAIT  | waiting for ext_ack_vld (or timeout when enabled)
module reg_native_if_arbiter
  import reg_native_if_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              native_clk,
  input  logic                              native_rst_n,
  input  logic [N_REQ-1:0]                  req_vld,
  input  logic [N_REQ*BUS_ADDR_WIDTH-1:0]   addr,
  input  logic [N_REQ-1:0]                  wr_en,
  input  logic [N_REQ-1:0]                  rd_en,
  input  logic [N_REQ*BUS_DATA_WIDTH-1:0]   wr_data,
  output logic [N_REQ-1:0]                  ack_vld,
  output logic [N_REQ-1:0]                  err,
  output logic [N_REQ*BUS_DATA_WIDTH-1:0]   rd_data,
  output logic                              ext_req_vld,
  input  logic                              ext_ack_vld,
  input  logic                              ext_err,
  output logic [BUS_ADDR_WIDTH-1:0]         ext_addr,
  output logic                              ext_wr_en,
  output logic                              ext_rd_en,
  output logic [BUS_DATA_WIDTH-1:0]         ext_wr_data,
  input  logic [BUS_DATA_WIDTH-1:0]         ext_rd_data
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int AW    = BUS_ADDR_WIDTH;
  localparam int DW    = BUS_DATA_WIDTH;

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("reg_native_if_arbiter: N_REQ or TIMEOUT_CYCLES out of range");
  end

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [AW-1:0]     cap_addr_q [N_REQ];
  logic [AW-1:0]     cap_addr_d [N_REQ];
  logic [DW-1:0]     cap_data_q [N_REQ];
  logic [DW-1:0]     cap_data_d [N_REQ];
  logic [N_REQ-1:0]  cap_wr_q, cap_wr_d, cap_rd_q, cap_rd_d;
  // Last granted requester; also the owner of the outstanding transaction.
  logic [IDX_W-1:0]  last_q, last_d;

  logic              ext_req_vld_q, ext_req_vld_d;
  logic [AW-1:0]     ext_addr_q, ext_addr_d;
  logic              ext_wr_en_q, ext_wr_en_d;
  logic              ext_rd_en_q, ext_rd_en_d;
  logic [DW-1:0]     ext_wr_data_q, ext_wr_data_d;
  logic [N_REQ-1:0]  ack_vld_q, ack_vld_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [N_REQ*DW-1:0] rd_data_q, rd_data_d;

  logic [N_REQ-1:0]  rr_grant;
  logic              rr_grant_vld;
  logic [IDX_W-1:0]  rr_idx;

  logic              done;
  logic              done_err;
  logic [DW-1:0]     done_data;

`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  reg_native_if_rr_arb #(
    .N_REQ (N_REQ)
  ) u_rr_arb (
    .pending   (pending_q),
    .last_idx  (last_q),
    .grant     (rr_grant),
    .grant_vld (rr_grant_vld)
  );

  // One-hot grant to index.
  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_grant[i]) rr_idx = IDX_W'(i);
    end
  end

  // FSM, completion and request capture.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    cap_addr_d    = cap_addr_q;
    cap_data_d    = cap_data_q;
    cap_wr_d      = cap_wr_q;
    cap_rd_d      = cap_rd_q;
    last_d        = last_q;
    ext_req_vld_d = 1'b0;
    ext_addr_d    = '0;
    ext_wr_en_d   = 1'b0;
    ext_rd_en_d   = 1'b0;
    ext_wr_data_d = '0;
    ack_vld_d     = '0;
    err_d         = '0;
    rd_data_d     = '0;
    done          = 1'b0;
    done_err      = 1'b0;
    done_data     = '0;
`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
    cnt_d         = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rr_grant_vld) begin
          last_d        = rr_idx;
          ext_req_vld_d = 1'b1;
          ext_addr_d    = cap_addr_q[rr_idx];
          ext_wr_en_d   = cap_wr_q[rr_idx];
          ext_rd_en_d   = cap_rd_q[rr_idx];
          ext_wr_data_d = cap_data_q[rr_idx];
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ext_ack_vld) begin
          done      = 1'b1;
          done_err  = ext_err;
          done_data = ext_rd_data;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ext_ack_vld) begin
          done      = 1'b1;
          done_err  = ext_err;
          done_data = ext_rd_data;
        end
`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d = ST_IDLE;
      for (int i = 0; i < N_REQ; i++) begin
        if (IDX_W'(i) == last_q) begin
          pending_d[i]              = 1'b0;
          ack_vld_d[i]              = 1'b1;
          err_d[i]                  = done_err;
          rd_data_d[i*DW +: DW]     = done_data;
        end
      end
    end

    // Evaluated after the clear so a pulse coinciding with completion is taken.
    for (int i = 0; i < N_REQ; i++) begin
      if (req_vld[i] && !pending_d[i]) begin
        pending_d[i]  = 1'b1;
        cap_addr_d[i] = addr[i*AW +: AW];
        cap_wr_d[i]   = wr_en[i];
        cap_rd_d[i]   = rd_en[i];
        cap_data_d[i] = wr_en[i] ? wr_data[i*DW +: DW] : '0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge native_clk) begin
    if (!native_rst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      cap_wr_q      <= '0;
      cap_rd_q      <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cap_addr_q[i] <= '0;
        cap_data_q[i] <= '0;
      end
      last_q        <= IDX_W'(N_REQ - 1);
      ext_req_vld_q <= 1'b0;
      ext_addr_q    <= '0;
      ext_wr_en_q   <= 1'b0;
      ext_rd_en_q   <= 1'b0;
      ext_wr_data_q <= '0;
      ack_vld_q     <= '0;
      err_q         <= '0;
      rd_data_q     <= '0;
`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cap_wr_q      <= cap_wr_d;
      cap_rd_q      <= cap_rd_d;
      cap_addr_q    <= cap_addr_d;
      cap_data_q    <= cap_data_d;
      last_q        <= last_d;
      ext_req_vld_q <= ext_req_vld_d;
      ext_addr_q    <= ext_addr_d;
      ext_wr_en_q   <= ext_wr_en_d;
      ext_rd_en_q   <= ext_rd_en_d;
      ext_wr_data_q <= ext_wr_data_d;
      ack_vld_q     <= ack_vld_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign ext_req_vld = ext_req_vld_q;
  assign ext_addr    = ext_addr_q;
  assign ext_wr_en   = ext_wr_en_q;
  assign ext_rd_en   = ext_rd_en_q;
  assign ext_wr_data = ext_wr_data_q;
  assign ack_vld     = ack_vld_q;
  assign err         = err_q;
  assign rd_data     = rd_data_q;

endmodule

// File: doc/reg_native_if_arbiter.md
REG_NATIVE_IF_ARBITER -- requirements
Module: reg_native_if_arbiter

Interface
REQ-001 Parameter N_REQ SHALL be provided: default 2, number of upstream reg_native_if requesters, range 2..8.
REQ-002 Parameter BUS_DATA_WIDTH SHALL be provided: default 32, data width.
REQ-003 Parameter BUS_ADDR_WIDTH SHALL be provided: default 64, address width.
REQ-004 Parameter TIMEOUT_CYCLES SHALL be provided: default 256, WAIT cycles before forced error response.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, with these ports:
- native_clk  input  1  sole clock
- native_rst_n  input  1  synchronous, active-low reset
REQ-006 Upstream ports SHALL be:
- req_vld  input  N_REQ  per-requester single-cycle request pulse
- addr  input  N_REQ*BUS_ADDR_WIDTH  packed, requester i at slice i
- wr_en  input  N_REQ  write qualifier
- rd_en  input  N_REQ  read qualifier
- wr_data  input  N_REQ*BUS_DATA_WIDTH  packed write data
- ack_vld  output  N_REQ  per-requester completion pulse
- err  output  N_REQ  error, valid with ack_vld
- rd_data  output  N_REQ*BUS_DATA_WIDTH  packed read data, valid with ack_vld
REQ-007 Downstream ports SHALL be:
- ext_req_vld  output  1  request pulse
- ext_ack_vld  input  1  completion pulse
- ext_err  input  1  downstream error
- ext_addr  output  BUS_ADDR_WIDTH  address
- ext_wr_en  output  1  write qualifier
- ext_rd_en  output  1  read qualifier
- ext_wr_data  output  BUS_DATA_WIDTH  write data
- ext_rd_data  input  BUS_DATA_WIDTH  read data

Function
REQ-008 A req_vld[i] pulse sampled at cycle t SHALL set pending[i] and capture addr, wr_en, rd_en and wr_data slice i at t+1.
- wr_data is captured as zero when wr_en=0.
REQ-009 A req_vld[i] pulse while pending[i]=1 SHALL be ignored; the first capture is kept.
REQ-010 FSM states SHALL be IDLE, ISSUE and WAIT.
- IDLE->ISSUE when any pending bit is set.
- ISSUE->WAIT after exactly one cycle.
- WAIT->IDLE on ext_ack_vld or timeout.
REQ-011 Grant SHALL be round-robin: in IDLE, search starts at the index after the last granted requester; after reset, requester 0 has highest priority.
REQ-012 Latency: a req_vld pulse at cycle t into an idle arbiter SHALL produce ext_req_vld=1 at cycle t+2, for exactly one cycle.
REQ-013 ext_addr, ext_wr_en, ext_rd_en and ext_wr_data SHALL carry the granted capture while ext_req_vld=1, and SHALL be zero otherwise.
REQ-014 ext_ack_vld SHALL be sampled in ISSUE and WAIT, and ignored in IDLE, so late or stray acks have no effect.
REQ-015 ext_ack_vld sampled at cycle u SHALL produce the following at u+1, for one cycle, with all else zero:
- ack_vld[g]=1
- err[g]=ext_err
- rd_data slice g = ext_rd_data
- pending[g] cleared
- state IDLE
REQ-016 A new req_vld[g] in the same cycle pending[g] clears SHALL be accepted as a new request.
REQ-017 All upstream and downstream outputs SHALL be registered; at most one transaction is outstanding downstream.

Reset
REQ-018 While native_rst_n=0 at a clock edge, the block SHALL reset:
- state IDLE
- all pending bits and captures cleared
- round-robin pointer set so requester 0 has highest priority
- timeout counter zero
- ack_vld, err, rd_data, ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data all zero
REQ-019 Reset mid-transaction SHALL discard the transaction; no ack_vld is ever issued for it.

Configuration
REQ-020 With macro REG_NATIVE_IF_ARB_TIMEOUT_EN defined, the block SHALL time out WAIT transactions:
- A counter increments each WAIT cycle.
- When it reaches TIMEOUT_CYCLES without ext_ack_vld, the next cycle gives ack_vld[g]=1, err[g]=1, rd_data slice g zero, and state IDLE.
- ext_ack_vld in the same cycle as expiry takes precedence.
REQ-021 Without REG_NATIVE_IF_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter logic is present, and TIMEOUT_CYCLES is unused.

Structure
REQ-022 Package reg_native_if_arb_pkg SHALL hold:
- the state enum typedef (IDLE, ISSUE, WAIT)
- the localparam limits for N_REQ
REQ-023 Round-robin selection SHALL live in sub-module reg_native_if_rr_arb.
- Inputs: pending vector and last-grant index.
- Outputs: one-hot grant and grant valid.

Verification
REQ-024 The bench SHALL cover single write: req_vld[0] at t with addr 0x10, wr_data 0xA5A5A5A5 -> ext_req_vld at t+2 with ext_wr_data 0xA5A5A5A5; ext_ack_vld at t+4 -> ack_vld[0]=1, err[0]=0 at t+5.
REQ-025 The bench SHALL cover simultaneous requests: req_vld=2'b11 after reset -> requester 0 served first, requester 1 second; repeated 2'b11 -> order 0,1,0,1.
REQ-026 The bench SHALL cover read data: requester 1 read, ext_rd_data=0xDEADBEEF with ext_err=1 -> rd_data slice 1 = 0xDEADBEEF, err[1]=1, rd_data slice 0 = 0.
REQ-027 The bench SHALL cover timeout (macro defined, TIMEOUT_CYCLES=4): no ext_ack_vld -> ack_vld[0]=1, err[0]=1, rd_data zero; a later stray ext_ack_vld produces no ack_vld.
REQ-028 The bench SHALL cover reset mid-operation: native_rst_n=0 in WAIT, then ext_ack_vld after release -> no ack_vld; all outputs zero during reset.
REQ-029 The bench SHALL cover duplicate pulse: second req_vld[0] while pending[0]=1 with a different addr -> only the first address is issued downstream.
